// File: rtl/light_game_ctrl.sv
// Round sequencer for the Catch-The-Light game: arms/releases the countdown
// timer, emits its per-second count enable, places a pseudo-random lit LED,
// judges button presses as hits or misses and keeps a saturating score.
module light_game_ctrl #(
  parameter int          N_LEDS     = 8,
  parameter int          TICK_DIV   = 50_000_000,
  parameter int          LIGHT_HOLD = 25_000_000,
  parameter int          SCORE_W    = 8,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_LEDS-1:0]  btn,
  input  logic               time_up,
  input  logic [4:0]         time_count,
  output logic               timer_rst,
  output logic               tick,
  output logic [N_LEDS-1:0]  led,
  output logic [SCORE_W-1:0] score,
  output logic               game_over,
  output logic [1:0]         state
);

  // state | meaning
  // IDLE  | waiting for first start, timer held in reset
  // ARM   | one cycle: clear score/counters, place first light
  // PLAY  | round running, ticks issued, presses judged
  // DONE  | time expired, score held, lights off
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int IW = $clog2(N_LEDS);
  localparam int TW = $clog2(TICK_DIV);
  localparam int HW = $clog2(LIGHT_HOLD);
  localparam logic [N_LEDS-1:0] ONE = {{(N_LEDS-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [N_LEDS-1:0]   led_q;
  logic [SCORE_W-1:0]  score_q;
  logic                timer_rst_q;
  logic                tick_q;
  logic                game_over_q;
  logic [7:0]          lfsr_q;
  logic [IW-1:0]       idx_q;
  logic [TW-1:0]       tick_cnt_q;
  logic [HW-1:0]       hold_cnt_q;

  logic [7:0]          lfsr_d;
  logic [IW-1:0]       cand_idx;
  logic [IW-1:0]       reloc_idx_d;
  logic                hit;
  logic                miss;
  logic                tick_wrap;
  logic                hold_exp;

  // time_count is status only; it never steers sequencing
  logic unused_time_count;
  assign unused_time_count = ^time_count;

  // Next light position: step LFSR once, avoid re-lighting the same LED
  always_comb begin
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    cand_idx    = lfsr_d[IW-1:0];
    reloc_idx_d = (cand_idx == idx_q) ? cand_idx + IW'(1) : cand_idx;
    hit         = (btn == led_q);
    miss        = (btn != '0) && !hit;
    tick_wrap   = (tick_cnt_q == TW'(TICK_DIV - 1));
    hold_exp    = (hold_cnt_q == HW'(LIGHT_HOLD - 1));
  end

  // Round FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      led_q       <= '0;
      score_q     <= '0;
      timer_rst_q <= 1'b1;
      tick_q      <= 1'b0;
      game_over_q <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      idx_q       <= '0;
      tick_cnt_q  <= '0;
      hold_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          timer_rst_q <= 1'b1;
          if (start) state_q <= S_ARM;
        end
        S_ARM: begin
          state_q     <= S_PLAY;
          timer_rst_q <= 1'b0;
          score_q     <= '0;
          tick_cnt_q  <= '0;
          hold_cnt_q  <= '0;
          tick_q      <= 1'b0;
          game_over_q <= 1'b0;
          idx_q       <= lfsr_q[IW-1:0];
          led_q       <= ONE << lfsr_q[IW-1:0];
        end
        S_PLAY: begin
          tick_cnt_q <= tick_wrap ? '0 : tick_cnt_q + TW'(1);
          if (time_up) begin
            // expiry wins over any press in the same cycle
            state_q     <= S_DONE;
            led_q       <= '0;
            tick_q      <= 1'b0;
            game_over_q <= 1'b1;
          end else begin
            tick_q <= tick_wrap;
            if (hit) begin
              if (score_q != '1) score_q <= score_q + SCORE_W'(1);
              lfsr_q     <= lfsr_d;
              idx_q      <= reloc_idx_d;
              led_q      <= ONE << reloc_idx_d;
              hold_cnt_q <= '0;
            end else if (miss) begin
              if (score_q != '0) score_q <= score_q - SCORE_W'(1);
            end else if (hold_exp) begin
              lfsr_q     <= lfsr_d;
              idx_q      <= reloc_idx_d;
              led_q      <= ONE << reloc_idx_d;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + HW'(1);
            end
          end
        end
        S_DONE: begin
          if (start) begin
            state_q     <= S_ARM;
            timer_rst_q <= 1'b1;
            game_over_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state     = state_q;
  assign led       = led_q;
  assign score     = score_q;
  assign timer_rst = timer_rst_q;
  assign tick      = tick_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_light_game_ctrl.sv
// Bench for light_game_ctrl with a game-level reference model.
module tb_light_game_ctrl;

  localparam int N  = 8;
  localparam int TD = 4;
  localparam int LH = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  btn = '0;
  logic        time_up = 1'b0;
  logic [4:0]  time_count = '0;
  logic        timer_rst, tick, game_over;
  logic [7:0]  led, score;
  logic [1:0]  state;

  int compared = 0;
  int mismatched = 0;

  light_game_ctrl #(.N_LEDS(N), .TICK_DIV(TD), .LIGHT_HOLD(LH), .SCORE_W(8),
                    .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .time_up(time_up),
    .time_count(time_count), .timer_rst(timer_rst), .tick(tick), .led(led),
    .score(score), .game_over(game_over), .state(state));

  always #5 clk = ~clk;

  // Reference model: game phase, score, lit index, hold age, cycles in play
  int m_phase, m_score, m_idx, m_hold, m_k, m_lfsr;

  function automatic int lfsr_step(input int l);
    int fb;
    fb = ((l >> 7) ^ (l >> 5) ^ (l >> 4) ^ (l >> 3)) & 1;
    return ((l << 1) | fb) & 255;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_score = 0; m_idx = 0; m_hold = 0; m_k = 0; m_lfsr = 8'hA5;
  endtask

  task automatic relocate();
    int c;
    m_lfsr = lfsr_step(m_lfsr);
    c = m_lfsr % N;
    if (c == m_idx) c = (c + 1) % N;
    m_idx = c;
    m_hold = 0;
  endtask

  task automatic model_clock();
    case (m_phase)
      0: if (start) m_phase = 1;
      1: begin
        m_phase = 2; m_score = 0; m_idx = m_lfsr % N; m_hold = 0; m_k = 0;
      end
      2: begin
        m_k++;
        if (time_up) m_phase = 3;
        else if (int'(btn) == (1 << m_idx)) begin
          if (m_score < 255) m_score++;
          relocate();
        end else if (btn != 0) begin
          if (m_score > 0) m_score--;
        end else if (m_hold == LH - 1) relocate();
        else m_hold++;
      end
      default: if (start) m_phase = 1;
    endcase
  endtask

  function automatic logic [20:0] exp_vec();
    logic [7:0] l;
    logic t;
    l = (m_phase == 2) ? 8'(1 << m_idx) : 8'h00;
    t = (m_phase == 2) && (m_k > 0) && (m_k % TD == 0);
    return {2'(m_phase), l, 8'(m_score), m_phase < 2, t, m_phase == 3};
  endfunction

  function automatic logic [20:0] got_vec();
    return {state, led, score, timer_rst, tick, game_over};
  endfunction

  task automatic advance();
    @(posedge clk);
    model_clock();
    #1;
    time_count = 5'($urandom_range(0, 31));
  endtask

  function automatic logic [7:0] lit_btn();
    return 8'(1 << m_idx);
  endfunction

  function automatic logic [7:0] unlit_btn();
    return 8'(1 << ((m_idx + 1 + $urandom_range(0, N - 2)) % N));
  endfunction

  task automatic test_reset();
    logic [20:0] g;
    rst = 1'b0; model_reset();
    #12;
    g = got_vec();
    compared++;
    if (g !== 21'h4) begin
      mismatched++; $display("FAIL reset_state got=%h exp=%h", g, 21'h4);
    end
    @(negedge clk); rst = 1'b1;
  endtask

  task automatic test_start_tick();
    logic [20:0] g, e;
    start = 1'b1; advance(); start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      g = got_vec(); e = exp_vec();
      compared++;
      if (g !== e) begin
        mismatched++; $display("FAIL start_tick cyc=%0d got=%h exp=%h", i, g, e);
      end
      if (i == 1) begin
        compared++;
        if (led !== 8'h20) begin
          mismatched++; $display("FAIL first_led got=%h exp=%h", led, 8'h20);
        end
      end
      advance();
    end
  endtask

  task automatic test_hit();
    logic [20:0] g, e;
    logic [7:0] prev;
    prev = lit_btn();
    btn = lit_btn(); advance(); btn = '0;
    compared++;
    if (led === prev || led === 8'h00) begin
      mismatched++; $display("FAIL hit_relocate got=%h prev=%h", led, prev);
    end
    for (int i = 0; i < LH + 2; i++) begin
      g = got_vec(); e = exp_vec();
      compared++;
      if (g !== e) begin
        mismatched++; $display("FAIL hit_hold cyc=%0d got=%h exp=%h", i, g, e);
      end
      advance();
    end
  endtask

  task automatic test_miss();
    logic [20:0] g, e;
    // bring score to 0 first via misses
    while (m_score > 0) begin btn = unlit_btn(); advance(); end
    btn = '0; advance();
    btn = unlit_btn(); advance(); btn = '0;
    g = got_vec(); e = exp_vec();
    compared++;
    if (g !== e || score !== 8'd0) begin
      mismatched++; $display("FAIL miss_at_zero got=%h exp=%h", g, e);
    end
    for (int i = 0; i < 3; i++) begin btn = lit_btn(); advance(); end
    btn = unlit_btn(); advance(); btn = '0;
    g = got_vec(); e = exp_vec();
    compared++;
    if (g !== e || score !== 8'd2) begin
      mismatched++; $display("FAIL miss_from_three got=%h exp=%h", g, e);
    end
    btn = lit_btn() | (lit_btn() == 8'h01 ? 8'h02 : 8'h01); advance(); btn = '0;
    g = got_vec(); e = exp_vec();
    compared++;
    if (g !== e || score !== 8'd1) begin
      mismatched++; $display("FAIL anti_mash got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_time_up();
    logic [20:0] g, e;
    btn = lit_btn(); time_up = 1'b1; advance(); btn = '0; time_up = 1'b0;
    for (int i = 0; i < 6; i++) begin
      g = got_vec(); e = exp_vec();
      compared++;
      if (g !== e) begin
        mismatched++; $display("FAIL done_hold cyc=%0d got=%h exp=%h", i, g, e);
      end
      advance();
    end
    start = 1'b1; advance(); start = 1'b0; advance();
    g = got_vec(); e = exp_vec();
    compared++;
    if (g !== e || score !== 8'd0 || state !== 2'd2) begin
      mismatched++; $display("FAIL restart got=%h exp=%h", g, e);
    end
  endtask

  task automatic test_random();
    logic [20:0] g, e;
    int r;
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 39);
      btn = '0; start = 1'b0; time_up = 1'b0;
      if (r < 16) btn = lit_btn();
      else if (r < 24) btn = 8'($urandom_range(1, 255));
      else if (r < 27) start = 1'b1;
      else if (r == 27) time_up = 1'b1;
      advance();
      btn = '0; start = 1'b0; time_up = 1'b0;
      g = got_vec(); e = exp_vec();
      compared++;
      if (g !== e) begin
        mismatched++; $display("FAIL random cyc=%0d got=%h exp=%h", i, g, e);
      end
    end
    if (m_phase != 2) begin
      start = 1'b1; advance(); start = 1'b0; advance();
    end
  endtask

  task automatic test_saturate_and_abort();
    logic [20:0] g, e;
    for (int i = 0; i < 260; i++) begin
      btn = lit_btn(); advance(); btn = '0;
      g = got_vec(); e = exp_vec();
      compared++;
      if (g !== e) begin
        mismatched++; $display("FAIL saturate cyc=%0d got=%h exp=%h", i, g, e);
      end
    end
    compared++;
    if (score !== 8'd255) begin
      mismatched++; $display("FAIL score_sat got=%0d exp=255", score);
    end
    #2 rst = 1'b0;
    #1 g = got_vec(); model_reset();
    compared++;
    if (g !== 21'h4) begin
      mismatched++; $display("FAIL async_abort got=%h exp=%h", g, 21'h4);
    end
    @(negedge clk); rst = 1'b1;
    advance();
    g = got_vec(); e = exp_vec();
    compared++;
    if (g !== e) begin
      mismatched++; $display("FAIL post_abort got=%h exp=%h", g, e);
    end
  endtask

  initial begin
    test_reset();
    test_start_tick();
    test_hit();
    test_miss();
    test_time_up();
    test_random();
    test_saturate_and_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
